// File: rtl/apd04_topk_heap_ctrl.sv
// Top-K min-heap controller. Keeps the K largest values seen so far as a
// 0-based min-heap in an external dual-port SRAM with 1-cycle registered
// read data. Insert sifts up, replace-root sifts down. The root value is
// mirrored in a register so heap_min never needs an SRAM read.
module apd04_topk_heap_ctrl #(
  parameter  int DATA_WIDTH = 16,
  parameter  int K          = 128,
  localparam int ADDR_WIDTH = $clog2(K),
  localparam int CNT_WIDTH  = $clog2(K + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  clr,
  output logic                  dropped,
  output logic [CNT_WIDTH-1:0]  count,
  output logic [DATA_WIDTH-1:0] heap_min,
  output logic                  heap_min_valid,
  output logic [DATA_WIDTH-1:0] ram_a_din,
  output logic                  ram_a_wen,
  output logic [ADDR_WIDTH-1:0] ram_a_waddr,
  output logic [ADDR_WIDTH-1:0] ram_a_raddr,
  input  logic [DATA_WIDTH-1:0] ram_a_dout,
  output logic [DATA_WIDTH-1:0] ram_b_din,
  output logic                  ram_b_wen,
  output logic [ADDR_WIDTH-1:0] ram_b_waddr,
  output logic [ADDR_WIDTH-1:0] ram_b_raddr,
  input  logic [DATA_WIDTH-1:0] ram_b_dout
);

  // One extra index bit so that child indices of the last level never wrap.
  localparam int                   IDX_W = ADDR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] K_CNT = CNT_WIDTH'(K);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DN = 2'd2} state_t;

  state_t                  state_q, state_nxt;
  logic [CNT_WIDTH-1:0]    count_q, count_nxt;
  logic [IDX_W-1:0]        hole_q, hole_nxt;
  logic [DATA_WIDTH-1:0]   x_q, x_nxt;
  logic [DATA_WIDTH-1:0]   min_q;

  logic                    accept, heap_empty, heap_full, acc_up, acc_root;
  logic [IDX_W-1:0]        count_ext, ins_par;
  logic [IDX_W-1:0]        up_p, up_pp;
  logic                    up_move, up_top;
  logic [IDX_W-1:0]        dn_l, dn_r, dn_c, dn_cl, dn_cr;
  logic                    dn_use_r, dn_move, dn_leaf;
  logic [DATA_WIDTH-1:0]   dn_cval;

  assign in_ready       = (state_q == IDLE) && !clr;
  assign accept         = in_valid && in_ready;
  assign count          = count_q;
  assign heap_min       = min_q;
  assign heap_min_valid = (count_q != '0);

  assign heap_empty = (count_q == '0);
  assign heap_full  = (count_q == K_CNT);
  assign acc_up     = accept && !heap_empty && !heap_full;
  assign acc_root   = accept && heap_full && (in_data > min_q);

  assign count_ext = IDX_W'(count_q);
  // Parent of the new hole when inserting at the end of the heap.
  assign ins_par   = (count_ext - IDX_W'(1)) >> 1;

  // Sift-up: parent value arrives on port A.
  assign up_p    = (hole_q - IDX_W'(1)) >> 1;
  assign up_pp   = (up_p - IDX_W'(1)) >> 1;
  assign up_move = (ram_a_dout > x_q);
  assign up_top  = (up_p == '0);

  // Sift-down: left child on port A, right child on port B. Left wins ties
  // and is forced when the right child lies beyond the valid entries.
  assign dn_l     = {hole_q[IDX_W-2:0], 1'b1};
  assign dn_r     = dn_l + IDX_W'(1);
  assign dn_use_r = (dn_r < count_ext) && (ram_b_dout < ram_a_dout);
  assign dn_c     = dn_use_r ? dn_r : dn_l;
  assign dn_cval  = dn_use_r ? ram_b_dout : ram_a_dout;
  assign dn_move  = (dn_cval < x_q);
  assign dn_cl    = {dn_c[IDX_W-2:0], 1'b1};
  assign dn_cr    = dn_cl + IDX_W'(1);
  assign dn_leaf  = (dn_cl >= count_ext);

  // State register; reset aborts any sift in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state: leave a sift once the new value has found its slot.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (acc_root)    state_nxt = DN;
        else if (acc_up) state_nxt = UP;
      end
      UP:      if (!up_move || up_top) state_nxt = IDLE;
      DN:      if (!dn_move || dn_leaf) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: SRAM commands, drop pulse and next values of the working registers.
  always_comb begin
    ram_a_din   = '0;
    ram_a_wen   = 1'b0;
    ram_a_waddr = '0;
    ram_a_raddr = '0;
    ram_b_din   = '0;
    ram_b_wen   = 1'b0;
    ram_b_waddr = '0;
    ram_b_raddr = '0;
    dropped     = 1'b0;
    count_nxt   = count_q;
    hole_nxt    = hole_q;
    x_nxt       = x_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          count_nxt = '0;
        end else if (accept) begin
          x_nxt = in_data;
          if (heap_empty) begin
            ram_b_wen   = 1'b1;
            ram_b_waddr = '0;
            ram_b_din   = in_data;
            count_nxt   = CNT_WIDTH'(1);
          end else if (!heap_full) begin
            hole_nxt    = count_ext;
            ram_a_raddr = ADDR_WIDTH'(ins_par);
            count_nxt   = count_q + CNT_WIDTH'(1);
          end else if (in_data > min_q) begin
            hole_nxt    = '0;
            ram_a_raddr = ADDR_WIDTH'(1);
            ram_b_raddr = ADDR_WIDTH'(2);
          end else begin
            dropped = 1'b1;
          end
        end
      end
      UP: begin
        if (up_move) begin
          ram_a_wen   = 1'b1;
          ram_a_waddr = ADDR_WIDTH'(hole_q);
          ram_a_din   = ram_a_dout;
          if (up_top) begin
            ram_b_wen   = 1'b1;
            ram_b_waddr = '0;
            ram_b_din   = x_q;
          end else begin
            hole_nxt    = up_p;
            ram_a_raddr = ADDR_WIDTH'(up_pp);
          end
        end else begin
          ram_b_wen   = 1'b1;
          ram_b_waddr = ADDR_WIDTH'(hole_q);
          ram_b_din   = x_q;
        end
      end
      DN: begin
        if (dn_move) begin
          ram_a_wen   = 1'b1;
          ram_a_waddr = ADDR_WIDTH'(hole_q);
          ram_a_din   = dn_cval;
          hole_nxt    = dn_c;
          if (dn_leaf) begin
            ram_b_wen   = 1'b1;
            ram_b_waddr = ADDR_WIDTH'(dn_c);
            ram_b_din   = x_q;
          end else begin
            ram_a_raddr = ADDR_WIDTH'(dn_cl);
            ram_b_raddr = ADDR_WIDTH'(dn_cr);
          end
        end else begin
          ram_b_wen   = 1'b1;
          ram_b_waddr = ADDR_WIDTH'(hole_q);
          ram_b_din   = x_q;
        end
      end
      default: ;
    endcase
    // Hold the SRAM interface quiet while reset is asserted.
    if (!rst_n) begin
      ram_a_din   = '0;
      ram_a_wen   = 1'b0;
      ram_a_waddr = '0;
      ram_a_raddr = '0;
      ram_b_din   = '0;
      ram_b_wen   = 1'b0;
      ram_b_waddr = '0;
      ram_b_raddr = '0;
      dropped     = 1'b0;
    end
  end

  // Control registers: entry count, hole index and the root mirror.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      hole_q  <= '0;
      min_q   <= '0;
    end else begin
      count_q <= count_nxt;
      hole_q  <= hole_nxt;
      if (ram_b_wen && (ram_b_waddr == '0))      min_q <= ram_b_din;
      else if (ram_a_wen && (ram_a_waddr == '0)) min_q <= ram_a_din;
    end
  end

  // Latched value being placed; pure data, no reset needed.
  always_ff @(posedge clk) begin
    x_q <= x_nxt;
  end

endmodule

// File: tb/tb_apd04_topk_heap_ctrl.sv
module tb_apd04_topk_heap_ctrl;
  localparam int DW = 8;
  localparam int KK = 4;
  localparam int AW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, clr;
  logic [DW-1:0] in_data;
  logic          in_ready, dropped, heap_min_valid;
  logic [CW-1:0] count;
  logic [DW-1:0] heap_min;
  logic [DW-1:0] ram_a_din, ram_a_dout, ram_b_din, ram_b_dout;
  logic          ram_a_wen, ram_b_wen;
  logic [AW-1:0] ram_a_waddr, ram_a_raddr, ram_b_waddr, ram_b_raddr;

  logic [DW-1:0] mem [0:KK-1];
  int            wr_count;
  int            vectors = 0;
  int            miscompares = 0;

  apd04_topk_heap_ctrl #(.DATA_WIDTH(DW), .K(KK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .clr(clr), .dropped(dropped), .count(count),
    .heap_min(heap_min), .heap_min_valid(heap_min_valid),
    .ram_a_din(ram_a_din), .ram_a_wen(ram_a_wen), .ram_a_waddr(ram_a_waddr),
    .ram_a_raddr(ram_a_raddr), .ram_a_dout(ram_a_dout),
    .ram_b_din(ram_b_din), .ram_b_wen(ram_b_wen), .ram_b_waddr(ram_b_waddr),
    .ram_b_raddr(ram_b_raddr), .ram_b_dout(ram_b_dout)
  );

  always #5 clk = ~clk;

  // Dual-port SRAM with registered read data; counts write strobes.
  always @(posedge clk) begin
    if (ram_a_wen) mem[ram_a_waddr] <= ram_a_din;
    if (ram_b_wen) mem[ram_b_waddr] <= ram_b_din;
    if (!rst_n) wr_count <= 0;
    else wr_count <= wr_count + int'(ram_a_wen) + int'(ram_b_wen);
    ram_a_dout <= mem[ram_a_raddr];
    ram_b_dout <= mem[ram_b_raddr];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int qmin(input int q[$]);
    int m = 1 << 30;
    foreach (q[i]) if (q[i] < m) m = q[i];
    return m;
  endfunction

  // Called at a negedge; steps negedges until in_ready, bounded.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL %s in_ready stuck low got %0b exp 1", tag, in_ready);
    end
  endtask

  task automatic offer(input logic [DW-1:0] v);
    @(negedge clk); in_valid = 1'b1; in_data = v;
    wait_ready("offer");
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h77; clr = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %0b exp 1", in_ready); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", count); end
    vectors++; if (heap_min_valid !== 1'b0) begin miscompares++; $display("FAIL rst_min_valid got %0b exp 0", heap_min_valid); end
    vectors++; if (heap_min !== 8'd0) begin miscompares++; $display("FAIL rst_heap_min got %0d exp 0", heap_min); end
    vectors++; if ({ram_a_wen, ram_b_wen, dropped} !== 3'b000) begin miscompares++; $display("FAIL rst_strobes got %b exp 000", {ram_a_wen, ram_b_wen, dropped}); end
    vectors++; if ({ram_a_waddr, ram_a_raddr, ram_b_waddr, ram_b_raddr, ram_a_din, ram_b_din} !== 24'h0) begin
      miscompares++; $display("FAIL rst_ram_bus got %h exp 0", {ram_a_waddr, ram_a_raddr, ram_b_waddr, ram_b_raddr, ram_a_din, ram_b_din}); end
    in_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_mem(input string tag, input logic [DW-1:0] e0, e1, e2, e3);
    logic [DW-1:0] e [0:KK-1];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int i = 0; i < KK; i++) begin
      vectors++;
      if (mem[i] !== e[i]) begin miscompares++; $display("FAIL %s mem[%0d] got %0d exp %0d", tag, i, mem[i], e[i]); end
    end
  endtask

  task automatic test_insert;
    offer(8'd50); offer(8'd30); offer(8'd40);
    @(negedge clk); in_valid = 1'b1; in_data = 8'd10;
    wait_ready("insert");
    #1;
    vectors++; if (ram_a_raddr !== 2'd1) begin miscompares++; $display("FAIL ins_T_raddr got %0d exp 1", ram_a_raddr); end
    @(posedge clk); #1 in_valid = 1'b0;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL ins_count_edge got %0d exp 4", count); end
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ins_T1_ready got %0b exp 0", in_ready); end
    vectors++; if ({ram_a_wen, ram_a_waddr, ram_a_din, ram_a_raddr, ram_b_wen} !== {1'b1, 2'd3, 8'd50, 2'd0, 1'b0}) begin
      miscompares++; $display("FAIL ins_T1_ports got %h exp %h", {ram_a_wen, ram_a_waddr, ram_a_din, ram_a_raddr, ram_b_wen}, {1'b1, 2'd3, 8'd50, 2'd0, 1'b0}); end
    @(negedge clk);
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ins_T2_ready got %0b exp 0", in_ready); end
    vectors++; if ({ram_a_wen, ram_a_waddr, ram_a_din, ram_b_wen, ram_b_waddr, ram_b_din} !== {1'b1, 2'd1, 8'd30, 1'b1, 2'd0, 8'd10}) begin
      miscompares++; $display("FAIL ins_T2_ports got %h exp %h", {ram_a_wen, ram_a_waddr, ram_a_din, ram_b_wen, ram_b_waddr, ram_b_din}, {1'b1, 2'd1, 8'd30, 1'b1, 2'd0, 8'd10}); end
    @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ins_T3_ready got %0b exp 1", in_ready); end
    vectors++; if (heap_min !== 8'd10) begin miscompares++; $display("FAIL ins_heap_min got %0d exp 10", heap_min); end
    check_mem("ins", 8'd10, 8'd30, 8'd40, 8'd50);
  endtask

  task automatic test_drop;
    int wc0;
    wc0 = wr_count;
    @(negedge clk); in_valid = 1'b1; in_data = 8'd5;
    wait_ready("drop");
    #1;
    vectors++; if ({dropped, ram_a_wen, ram_b_wen} !== 3'b100) begin miscompares++; $display("FAIL drop1 got %b exp 100", {dropped, ram_a_wen, ram_b_wen}); end
    @(posedge clk); #1 in_data = 8'd10;
    @(negedge clk);
    vectors++; if ({in_ready, dropped, ram_a_wen, ram_b_wen} !== 4'b1100) begin miscompares++; $display("FAIL drop2 got %b exp 1100", {in_ready, dropped, ram_a_wen, ram_b_wen}); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (dropped !== 1'b0) begin miscompares++; $display("FAIL drop_idle got %0b exp 0", dropped); end
    vectors++; if (wr_count !== wc0) begin miscompares++; $display("FAIL drop_writes got %0d exp %0d", wr_count, wc0); end
    vectors++; if ({count, heap_min} !== {3'd4, 8'd10}) begin miscompares++; $display("FAIL drop_state got %h exp %h", {count, heap_min}, {3'd4, 8'd10}); end
    check_mem("drop", 8'd10, 8'd30, 8'd40, 8'd50);
  endtask

  task automatic test_replace;
    @(negedge clk); in_valid = 1'b1; in_data = 8'd35;
    wait_ready("replace");
    #1;
    vectors++; if ({ram_a_raddr, ram_b_raddr, dropped} !== {2'd1, 2'd2, 1'b0}) begin
      miscompares++; $display("FAIL rep_T_reads got %h exp %h", {ram_a_raddr, ram_b_raddr, dropped}, {2'd1, 2'd2, 1'b0}); end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    vectors++; if ({in_ready, ram_a_wen, ram_a_waddr, ram_a_din, ram_a_raddr, ram_b_wen} !== {1'b0, 1'b1, 2'd0, 8'd30, 2'd3, 1'b0}) begin
      miscompares++; $display("FAIL rep_T1 got %h exp %h", {in_ready, ram_a_wen, ram_a_waddr, ram_a_din, ram_a_raddr, ram_b_wen}, {1'b0, 1'b1, 2'd0, 8'd30, 2'd3, 1'b0}); end
    @(negedge clk);
    vectors++; if ({ram_a_wen, ram_b_wen, ram_b_waddr, ram_b_din} !== {1'b0, 1'b1, 2'd1, 8'd35}) begin
      miscompares++; $display("FAIL rep_T2 got %h exp %h", {ram_a_wen, ram_b_wen, ram_b_waddr, ram_b_din}, {1'b0, 1'b1, 2'd1, 8'd35}); end
    @(negedge clk);
    vectors++; if ({in_ready, count, heap_min} !== {1'b1, 3'd4, 8'd30}) begin
      miscompares++; $display("FAIL rep_done got %h exp %h", {in_ready, count, heap_min}, {1'b1, 3'd4, 8'd30}); end
    check_mem("rep", 8'd30, 8'd35, 8'd40, 8'd50);
  endtask

  task automatic test_clear;
    @(negedge clk); in_valid = 1'b1; in_data = 8'd99; clr = 1'b1;
    #1;
    vectors++; if ({in_ready, ram_a_wen, ram_b_wen, dropped} !== 4'b0000) begin
      miscompares++; $display("FAIL clr_idle got %b exp 0000", {in_ready, ram_a_wen, ram_b_wen, dropped}); end
    @(posedge clk); #1;
    vectors++; if ({count, heap_min_valid} !== {3'd0, 1'b0}) begin
      miscompares++; $display("FAIL clr_count got %h exp 0", {count, heap_min_valid}); end
    clr = 1'b0; in_valid = 1'b0;
    offer(8'd20); offer(8'd25); offer(8'd30); offer(8'd35);
    @(negedge clk); in_valid = 1'b1; in_data = 8'd40;
    wait_ready("clr_dn");
    @(posedge clk); #1 in_valid = 1'b0; clr = 1'b1;
    @(negedge clk);
    vectors++; if ({in_ready, ram_a_wen, ram_a_waddr, ram_a_din} !== {1'b0, 1'b1, 2'd0, 8'd25}) begin
      miscompares++; $display("FAIL clr_dn_step got %h exp %h", {in_ready, ram_a_wen, ram_a_waddr, ram_a_din}, {1'b0, 1'b1, 2'd0, 8'd25}); end
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    wait_ready("clr_dn_end");
    vectors++; if ({count, heap_min} !== {3'd4, 8'd25}) begin
      miscompares++; $display("FAIL clr_dn_ignored got %h exp %h", {count, heap_min}, {3'd4, 8'd25}); end
    check_mem("clr_dn", 8'd25, 8'd35, 8'd30, 8'd40);
  endtask

  task automatic test_reset_mid;
    @(negedge clk); in_valid = 1'b1; in_data = 8'd200;
    wait_ready("rst_mid");
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    vectors++; if ({count, in_ready, heap_min_valid, heap_min} !== {3'd0, 1'b1, 1'b0, 8'd0}) begin
      miscompares++; $display("FAIL rst_mid_state got %h exp %h", {count, in_ready, heap_min_valid, heap_min}, {3'd0, 1'b1, 1'b0, 8'd0}); end
    vectors++; if ({ram_a_wen, ram_b_wen, dropped} !== 3'b000) begin
      miscompares++; $display("FAIL rst_mid_strobes got %b exp 000", {ram_a_wen, ram_b_wen, dropped}); end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random;
    int model[$];
    int got[$];
    int v, busy, em, mi;
    bit exp_drop, single;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        clr = 1'b1; in_valid = ($urandom_range(0, 1) == 1); in_data = 8'hFF;
        @(posedge clk); #1 clr = 1'b0; in_valid = 1'b0;
        model.delete();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rnd_clr got %0d exp 0", count); end
        @(negedge clk);
      end
      v = $urandom_range(0, 63);
      exp_drop = (model.size() == KK) && (v <= qmin(model));
      single = exp_drop || (model.size() == 0);
      in_valid = 1'b1; in_data = v[DW-1:0];
      #1;
      vectors++; if ({in_ready, dropped} !== {1'b1, exp_drop}) begin
        miscompares++; $display("FAIL rnd_accept v=%0d got %b exp %b", v, {in_ready, dropped}, {1'b1, exp_drop}); end
      @(posedge clk); #1 in_valid = 1'b0;
      if (model.size() < KK) model.push_back(v);
      else if (!exp_drop) begin
        mi = 0;
        foreach (model[i]) if (model[i] < model[mi]) mi = i;
        model[mi] = v;
      end
      busy = 0;
      @(negedge clk);
      while (!in_ready && busy < 20) begin busy++; @(negedge clk); end
      vectors++; if (single ? (busy != 0) : (busy < 1 || busy > 2)) begin
        miscompares++; $display("FAIL rnd_latency v=%0d got %0d busy cycles exp %s", v, busy, single ? "0" : "1..2"); end
      vectors++; if (count !== model.size()) begin miscompares++; $display("FAIL rnd_count got %0d exp %0d", count, model.size()); end
      if (model.size() > 0) begin
        em = qmin(model);
        vectors++; if ({heap_min_valid, heap_min} !== {1'b1, em[DW-1:0]}) begin
          miscompares++; $display("FAIL rnd_heap_min got %0d exp %0d", heap_min, em); end
      end
    end
    for (int i = 0; i < int'(count); i++) got.push_back(int'(mem[i]));
    got.sort(); model.sort();
    vectors++;
    if (got.size() != model.size()) begin
      miscompares++; $display("FAIL rnd_final_size got %0d exp %0d", got.size(), model.size());
    end else begin
      foreach (got[i]) begin
        vectors++; if (got[i] != model[i]) begin miscompares++; $display("FAIL rnd_final_elem[%0d] got %0d exp %0d", i, got[i], model[i]); end
      end
    end
    for (int i = 1; i < int'(count); i++) begin
      vectors++; if (mem[(i-1)/2] > mem[i]) begin
        miscompares++; $display("FAIL rnd_heap_order parent %0d got %0d exp <= %0d", (i-1)/2, mem[(i-1)/2], mem[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_insert;
    test_drop;
    test_replace;
    test_clear;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
